truth_table_sweeper: RTL and testbench
======================================

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter EXPECTED, default 16'h69FA, golden truth table: bit i is the required F output for input vector i = {a,b,c,d}.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a sweep; sampled on rising edge of clk.
REQ-005 y_in  input  1  response of the 4-input function under test (combinational, driven from vec).
REQ-006 vec  output  4  stimulus vector {a,b,c,d} = vec[3:0], driven to the function under test.
REQ-007 busy  output  1  high while state is SWEEP.
REQ-008 done  output  1  high while state is DONE.
REQ-009 pass  output  1  valid when done; high iff captured table equals EXPECTED.
REQ-010 table_out  output  16  captured truth table; bit i holds y_in sampled with vec == i.
REQ-011 err_count  output  5  number of mismatching entries, 0..16.
REQ-012 err_seen  output  1  high once any mismatch has been captured in the current sweep.
REQ-013 first_err  output  4  lowest vector index that mismatched; valid only when err_seen is high.

Function
REQ-014 FSM states: IDLE, SWEEP, DONE; binary encoding.
REQ-015 IDLE: start=1 -> SWEEP at next edge; vec<=0; table_out, err_count, err_seen, first_err cleared.
REQ-016 SWEEP: each edge captures y_in into table_out[vec], compares against EXPECTED[vec], then vec<=vec+1.
REQ-017 One entry per cycle; vec held stable a full cycle before its sample edge; sweep lasts exactly 16 cycles.
REQ-018 Mismatch: err_count<=err_count+1; if err_seen==0, first_err<=vec and err_seen<=1.
REQ-019 Capture at vec==15 -> DONE at same edge; vec wraps to 0; no 17th capture.
REQ-020 err_count is 5 bits and never wraps; 16 mismatches yields 5'd16.
REQ-021 pass = done & (err_count==0), combinational from registered state.
REQ-022 DONE: results held stable; start=1 -> SWEEP with same clearing as REQ-015.
REQ-023 start while in SWEEP is ignored; the sweep runs to completion.
REQ-024 start held continuously causes back-to-back sweeps, one DONE cycle between them.
REQ-025 Latency start-sampled -> done: 17 rising edges.

Reset
REQ-026 reset=1 at an edge overrides every other input, including start.
REQ-027 reset values: state IDLE, vec 0, busy 0, done 0, pass 0, table_out 0, err_count 0, err_seen 0, first_err 0.
REQ-028 reset mid-SWEEP aborts; partial results discarded; no done pulse produced.

Structure
REQ-029 State encoding constants and default golden table 16'h69FA live in the shared chapter definitions package/include.
REQ-030 Vector index is one sub-module counter_4bit: synchronous clear, enable, wrap 15->0, terminal-count output used for REQ-019.
REQ-031 Remaining logic (FSM, capture register, comparator, error tracking) is in the top module; no latches, single clock domain.

Verification
REQ-032 Correct function connected, reset, pulse start -> busy 16 cycles, vec 0..15 in order, done at edge 17, table_out=16'h69FA, pass=1, err_count=0.
REQ-033 y_in tied 1 -> table_out=16'hFFFF, err_count=6, first_err=0, err_seen=1, pass=0.
REQ-034 y_in forced inverted on vec==9 only -> table_out=16'h69F8... corrected: 16'h6BFA, err_count=1, first_err=9, pass=0.
REQ-035 reset asserted when vec==7 -> next cycle IDLE, all outputs 0; new start yields full clean sweep, pass=1.
REQ-036 start pulsed again at vec==5 in SWEEP -> ignored, single done at edge 17; start held high -> sweeps repeat, done high one cycle between them.
REQ-037 y_in tied 0 with EXPECTED overridden to 16'hFFFF -> err_count=16, first_err=0, pass=0.

Source files
------------

// File: rtl/truth_table_sweeper_pkg.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper_pkg
// Shared definitions for the truth-table sweeper: FSM state encoding, field
// widths, the default golden truth table and the per-entry compare helper.
// No ports (package).
// -----------------------------------------------------------------------------
package truth_table_sweeper_pkg;

  localparam int unsigned VEC_W = 4;
  localparam int unsigned TBL_W = 16;
  localparam int unsigned ERR_W = 5;

  // Binary-encoded sweeper states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SWEEP = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Golden truth table: bit i is the required F output for input vector i.
  localparam logic [TBL_W-1:0] DEFAULT_EXPECTED = 16'h69FA;

  // Largest value err_count can reach: one mismatch per table entry.
  localparam logic [ERR_W-1:0] ERR_MAX = 5'd16;

  // True when the sampled response differs from the golden entry at idx.
  function automatic logic entry_mismatch(
    input logic [TBL_W-1:0] golden,
    input logic [VEC_W-1:0] idx,
    input logic             sample
  );
    return (golden[idx] != sample);
  endfunction

endpackage : truth_table_sweeper_pkg

// File: rtl/truth_table_sweeper_if.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper_if
// Groups the sweep request, the function-under-test loop (vec out, y_in back)
// and the result bus.
//   master : the requester / function under test (drives start, y_in)
//   slave  : the sweeper itself (drives vec and all result signals)
// -----------------------------------------------------------------------------
interface truth_table_sweeper_if;
  import truth_table_sweeper_pkg::*;

  logic             start;      // request a sweep
  logic             y_in;       // response of the function under test
  logic [VEC_W-1:0] vec;        // stimulus vector {a,b,c,d}
  logic             busy;       // sweep in progress
  logic             done;       // results valid and held
  logic             pass;       // done and no mismatches
  logic [TBL_W-1:0] table_out;  // captured truth table
  logic [ERR_W-1:0] err_count;  // number of mismatching entries
  logic             err_seen;   // at least one mismatch captured
  logic [VEC_W-1:0] first_err;  // lowest mismatching index

  modport master (
    output start,
    output y_in,
    input  vec,
    input  busy,
    input  done,
    input  pass,
    input  table_out,
    input  err_count,
    input  err_seen,
    input  first_err
  );

  modport slave (
    input  start,
    input  y_in,
    output vec,
    output busy,
    output done,
    output pass,
    output table_out,
    output err_count,
    output err_seen,
    output first_err
  );

endinterface : truth_table_sweeper_if

// File: rtl/truth_table_sweeper_counter_4bit.sv
// -----------------------------------------------------------------------------
// counter_4bit
// Vector index counter for the sweeper. Synchronous clear has priority over
// enable; the count wraps 15 -> 0. tc_o flags the terminal count (15).
// Ports:
//   clk      in   clock
//   reset    in   synchronous active-high reset
//   clr_i    in   synchronous clear to 0
//   en_i     in   advance by one
//   count_o  out  current count
//   tc_o     out  count == 15
// -----------------------------------------------------------------------------
module counter_4bit (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [3:0] count_o,
  output logic       tc_o
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  // Next count: clear wins, otherwise increment (natural 4-bit wrap) or hold.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 4'd0;
    end else if (en_i) begin
      count_d = count_q + 4'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == 4'hF);

endmodule : counter_4bit

// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
// Drives every 4-bit input vector to a function under test, captures its
// response into a 16-entry truth table, and compares it against EXPECTED.
// One entry per cycle; a full sweep is 16 capture edges after the start edge.
// Ports:
//   clk    in   clock, all state on rising edge
//   reset  in   synchronous active-high reset (overrides start)
//   bus    slave modport of truth_table_sweeper_if:
//            start, y_in in; vec, busy, done, pass, table_out,
//            err_count, err_seen, first_err out
// Parameter:
//   EXPECTED  golden truth table, bit i = required F for vector i
// -----------------------------------------------------------------------------
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter logic [TBL_W-1:0] EXPECTED = DEFAULT_EXPECTED
) (
  input  logic                  clk,
  input  logic                  reset,
  truth_table_sweeper_if.slave  bus
);

  state_e           state_q;
  logic             busy_q;
  logic             done_q;
  logic [TBL_W-1:0] table_q;
  logic [TBL_W-1:0] table_d;
  logic [ERR_W-1:0] err_count_q;
  logic [ERR_W-1:0] err_count_d;
  logic             err_seen_q;
  logic [VEC_W-1:0] first_err_q;

  logic [VEC_W-1:0] vec_s;
  logic             tc_s;
  logic             cnt_clr_s;
  logic             cnt_en_s;
  logic             mismatch_s;
  logic             launch_s;

  // A new sweep may only be launched from IDLE or DONE; start during SWEEP is
  // deliberately ignored so a sweep always runs to completion.
  assign launch_s  = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign cnt_clr_s = launch_s;
  assign cnt_en_s  = (state_q == ST_SWEEP);

  counter_4bit u_counter (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (cnt_clr_s),
    .en_i    (cnt_en_s),
    .count_o (vec_s),
    .tc_o    (tc_s)
  );

  assign mismatch_s = entry_mismatch(EXPECTED, vec_s, bus.y_in);

  // Capture and error-count next values for the entry currently on vec.
  always_comb begin
    table_d        = table_q;
    table_d[vec_s] = bus.y_in;
    err_count_d    = err_count_q;
    // Saturate at 16 so the count can never wrap even if a 17th compare
    // were ever to slip in.
    if (mismatch_s && (err_count_q != ERR_MAX)) begin
      err_count_d = err_count_q + 5'd1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // Sweeper FSM with registered busy/done and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      table_q     <= 16'h0000;
      err_count_q <= 5'd0;
      err_seen_q  <= 1'b0;
      first_err_q <= 4'd0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_q     <= ST_SWEEP;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            table_q     <= 16'h0000;
            err_count_q <= 5'd0;
            err_seen_q  <= 1'b0;
            first_err_q <= 4'd0;
          end else begin
            // Results stay frozen until the next launch.
            state_q <= state_q;
            busy_q  <= 1'b0;
            done_q  <= (state_q == ST_DONE);
          end
        end
        ST_SWEEP: begin
          table_q     <= table_d;
          err_count_q <= err_count_d;
          // Only the first mismatch of a sweep sets first_err.
          if (mismatch_s && !err_seen_q) begin
            err_seen_q  <= 1'b1;
            first_err_q <= vec_s;
          end else begin
            err_seen_q  <= err_seen_q;
            first_err_q <= first_err_q;
          end
          // Entry 15 is the last capture; leave SWEEP on the same edge so
          // the wrapped vec 0 is never sampled a 17th time.
          if (tc_s) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_SWEEP;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.vec       = vec_s;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = done_q && (err_count_q == 5'd0);
  assign bus.table_out = table_q;
  assign bus.err_count = err_count_q;
  assign bus.err_seen  = err_seen_q;
  assign bus.first_err = first_err_q;

endmodule : truth_table_sweeper

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sweeper
// Directed bench for truth_table_sweeper. dut_a uses the default golden table
// with a selectable function under test; dut_b overrides EXPECTED to 16'hFFFF
// with y_in tied low.
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;

  localparam logic [15:0] GOLDEN = 16'h69FA;

  logic clk;
  logic reset;
  logic [1:0] mode;   // 0 golden F, 1 tied 1, 2 tied 0, 3 golden but inverted at vec 9

  int checks;
  int failures;

  truth_table_sweeper_if bus_a ();
  truth_table_sweeper_if bus_b ();

  truth_table_sweeper dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  truth_table_sweeper #(.EXPECTED(16'hFFFF)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Function under test for dut_a.
  always_comb begin
    case (mode)
      2'd0:    bus_a.y_in = GOLDEN[bus_a.vec];
      2'd1:    bus_a.y_in = 1'b1;
      2'd2:    bus_a.y_in = 1'b0;
      2'd3:    bus_a.y_in = (bus_a.vec == 4'd9) ? ~GOLDEN[bus_a.vec] : GOLDEN[bus_a.vec];
      default: bus_a.y_in = 1'b0;
    endcase
  end

  assign bus_b.y_in = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start on dut_a and count rising edges until done (bounded).
  task automatic run_sweep(output int edges);
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    edges = 1;
    while (!bus_a.done && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  initial begin
    int edges;
    int done_cnt;
    int first_done;
    int second_done;
    logic busy_at18;
    logic saw_done;

    checks      = 0;
    failures    = 0;
    mode        = 2'd0;
    reset       = 1'b1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state.
    check("rst_vec",   32'(bus_a.vec),       32'h0);
    check("rst_busy",  32'(bus_a.busy),      32'h0);
    check("rst_done",  32'(bus_a.done),      32'h0);
    check("rst_pass",  32'(bus_a.pass),      32'h0);
    check("rst_table", 32'(bus_a.table_out), 32'h0);
    check("rst_err",   32'(bus_a.err_count), 32'h0);
    check("rst_seen",  32'(bus_a.err_seen),  32'h0);
    check("rst_first", 32'(bus_a.first_err), 32'h0);

    // Correct function: busy 16 cycles, vec 0..15 in order, done at edge 17.
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("golden_vec%0d", k),  32'(bus_a.vec),  32'(k));
      check($sformatf("golden_busy%0d", k), 32'(bus_a.busy), 32'h1);
      check($sformatf("golden_done%0d", k), 32'(bus_a.done), 32'h0);
      tick();
    end
    check("golden_done",  32'(bus_a.done),      32'h1);
    check("golden_busy",  32'(bus_a.busy),      32'h0);
    check("golden_table", 32'(bus_a.table_out), 32'h69FA);
    check("golden_pass",  32'(bus_a.pass),      32'h1);
    check("golden_err",   32'(bus_a.err_count), 32'h0);
    check("golden_seen",  32'(bus_a.err_seen),  32'h0);
    check("golden_vec_wrap", 32'(bus_a.vec),    32'h0);
    tick();
    tick();
    check("hold_done",  32'(bus_a.done),      32'h1);
    check("hold_table", 32'(bus_a.table_out), 32'h69FA);

    // y_in tied 1: the six zero entries of 69FA mismatch, lowest is 0.
    mode = 2'd1;
    run_sweep(edges);
    check("ones_latency", 32'(edges),           32'd17);
    check("ones_table",   32'(bus_a.table_out), 32'hFFFF);
    check("ones_err",     32'(bus_a.err_count), 32'd6);
    check("ones_first",   32'(bus_a.first_err), 32'd0);
    check("ones_seen",    32'(bus_a.err_seen),  32'h1);
    check("ones_pass",    32'(bus_a.pass),      32'h0);

    // Single inverted entry at vec 9.
    mode = 2'd3;
    run_sweep(edges);
    check("inv9_latency", 32'(edges),           32'd17);
    check("inv9_table",   32'(bus_a.table_out), 32'h6BFA);
    check("inv9_err",     32'(bus_a.err_count), 32'd1);
    check("inv9_first",   32'(bus_a.first_err), 32'd9);
    check("inv9_seen",    32'(bus_a.err_seen),  32'h1);
    check("inv9_pass",    32'(bus_a.pass),      32'h0);

    // Reset at vec 7 aborts the sweep and clears everything.
    mode = 2'd0;
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    for (int i = 0; i < 20 && bus_a.vec != 4'd7; i++) tick();
    check("abort_at7", 32'(bus_a.vec), 32'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_vec",   32'(bus_a.vec),       32'h0);
    check("abort_busy",  32'(bus_a.busy),      32'h0);
    check("abort_done",  32'(bus_a.done),      32'h0);
    check("abort_pass",  32'(bus_a.pass),      32'h0);
    check("abort_table", 32'(bus_a.table_out), 32'h0);
    check("abort_err",   32'(bus_a.err_count), 32'h0);
    check("abort_seen",  32'(bus_a.err_seen),  32'h0);
    check("abort_first", 32'(bus_a.first_err), 32'h0);
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus_a.done || bus_a.busy) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 32'h0);
    run_sweep(edges);
    check("after_abort_latency", 32'(edges),           32'd17);
    check("after_abort_table",   32'(bus_a.table_out), 32'h69FA);
    check("after_abort_pass",    32'(bus_a.pass),      32'h1);

    // Second start pulse at vec 5 is ignored.
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    edges = 1;
    while (bus_a.vec != 4'd5 && edges < 40) begin
      tick();
      edges++;
    end
    bus_a.start = 1'b1;
    tick();
    edges++;
    bus_a.start = 1'b0;
    while (!bus_a.done && edges < 40) begin
      tick();
      edges++;
    end
    check("restart_ign_latency", 32'(edges), 32'd17);
    tick();
    tick();
    tick();
    check("restart_ign_busy", 32'(bus_a.busy), 32'h0);
    check("restart_ign_done", 32'(bus_a.done), 32'h1);
    check("restart_ign_pass", 32'(bus_a.pass), 32'h1);

    // start held high: back-to-back sweeps, one DONE cycle between them.
    bus_a.start = 1'b1;
    done_cnt    = 0;
    first_done  = 0;
    second_done = 0;
    busy_at18   = 1'b0;
    for (int t = 1; t <= 34; t++) begin
      tick();
      if (t == 18) busy_at18 = bus_a.busy;
      if (bus_a.done) begin
        done_cnt++;
        if (first_done == 0) first_done = t;
        else if (second_done == 0) second_done = t;
      end
    end
    bus_a.start = 1'b0;
    check("b2b_first_done",  32'(first_done),  32'd17);
    check("b2b_busy_after",  32'(busy_at18),   32'h1);
    check("b2b_second_done", 32'(second_done), 32'd34);
    check("b2b_done_cycles", 32'(done_cnt),    32'd2);
    tick();
    check("b2b_hold_done", 32'(bus_a.done), 32'h1);
    check("b2b_hold_pass", 32'(bus_a.pass), 32'h1);

    // dut_b: EXPECTED = FFFF with y_in tied 0 -> all 16 entries mismatch.
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    edges = 1;
    while (!bus_b.done && edges < 40) begin
      tick();
      edges++;
    end
    check("all_err_latency", 32'(edges),           32'd17);
    check("all_err_table",   32'(bus_b.table_out), 32'h0);
    check("all_err_count",   32'(bus_b.err_count), 32'd16);
    check("all_err_first",   32'(bus_b.first_err), 32'd0);
    check("all_err_seen",    32'(bus_b.err_seen),  32'h1);
    check("all_err_pass",    32'(bus_b.pass),      32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_truth_table_sweeper
